// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM state type and frame constants for the program loader
package prog_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;
  localparam logic [7:0] LEN_MASK   = 8'hF0;
  localparam logic [7:0] CLEAR_WORD = 8'h00;
  function automatic logic [4:0] frame_len(input logic [7:0] b);
    return (b[3:0] == 4'd0) ? 5'd16 : {1'b0, b[3:0]};
  endfunction
endpackage

// File: rtl/prog_loader_inst_ram.sv
// inst_ram: instruction store with synchronous write and asynchronous read
module inst_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  // write port; contents are intentionally never reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length/data/checksum frame, fills the instruction RAM and releases the CPU
module prog_loader import prog_loader_pkg::*; #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_inst,
  input  logic          cpu_ok,
  input  logic          reload,
  output logic          cpu_rst,
  output logic          loaded,
  output logic          err,
  output logic          done
);
  state_t        r_state;
  logic [3:0]    r_ptr;
  logic [7:0]    r_sum;
  logic [4:0]    r_n;
  logic          r_in_ready, r_cpu_rst, r_loaded, r_err, r_done;
  logic          w_acc, w_len_ok, w_last, w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  assign w_acc    = in_valid & r_in_ready;
  assign w_len_ok = (in_data & LEN_MASK) == 8'h00;
  assign w_last   = {1'b0, r_ptr} == r_n - 5'd1;

  // RAM write port: one clearing write per CLEAR cycle, or the accepted byte during LOAD
  always_comb begin
    w_we    = (r_state == S_CLEAR) || (r_state == S_LOAD && w_acc);
    w_waddr = AW'(r_ptr);
    w_wdata = (r_state == S_CLEAR) ? DW'(CLEAR_WORD) : DW'(in_data);
  end

  inst_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (fetch_addr),
    .o_rdata (fetch_inst)
  );

  // loader FSM; outputs are registered and updated together with the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_sum      <= '0;
      r_n        <= '0;
      r_in_ready <= 1'b1;
      r_cpu_rst  <= 1'b1;
      r_loaded   <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: if (w_acc) begin
          if (w_len_ok) begin
            r_state    <= S_CLEAR;
            r_n        <= frame_len(in_data);
            r_ptr      <= '0;
            r_in_ready <= 1'b0;
            r_err      <= 1'b0;
          end else begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + 4'd1;
          if (r_ptr == 4'd15) begin
            r_state    <= S_LOAD;
            r_sum      <= '0;
            r_in_ready <= 1'b1;
          end
        end
        S_LOAD: if (w_acc) begin
          r_sum <= r_sum + in_data;
          if (w_last) begin
            r_ptr   <= '0;
            r_state <= S_CHECK;
          end else r_ptr <= r_ptr + 4'd1;
        end
        S_CHECK: if (w_acc) begin
          if (in_data == r_sum) begin
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_cpu_rst  <= 1'b0;
            r_loaded   <= 1'b1;
          end else begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
          end
        end
        S_RUN: begin
          if (reload) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_cpu_rst  <= 1'b1;
            r_loaded   <= 1'b0;
            r_done     <= 1'b0;
          end else if (cpu_ok) r_done <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign cpu_rst  = r_cpu_rst;
  assign loaded   = r_loaded;
  assign err      = r_err;
  assign done     = r_done;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven and randomized frame checks of prog_loader against a frame-level model
module tb_prog_loader;
  logic       clk = 0, rst_n = 0, in_valid = 0, reload = 0, cpu_ok = 0;
  logic [7:0] in_data = 0;
  logic [3:0] fetch_addr = 0;
  logic [7:0] fetch_inst;
  logic       in_ready, cpu_rst, loaded, err, done;
  int         errors = 0, checks = 0;
  logic [7:0] mdl_mem [16];
  bit         mdl_run = 0;

  typedef struct {
    logic [7:0]   len;
    logic [127:0] data;
    logic [7:0]   ck;
    bit           exp_run;
  } vec_t;
  vec_t tbl [6];

  prog_loader #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fetch_addr(fetch_addr), .fetch_inst(fetch_inst), .cpu_ok(cpu_ok), .reload(reload),
    .cpu_rst(cpu_rst), .loaded(loaded), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int k;
    k = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1;
    in_data  = b;
    while (!in_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (k >= 64) chk("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_data  = 8'($urandom);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) begin
      fetch_addr = 4'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), 32'(fetch_inst), 32'(mdl_mem[i]));
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1;
    @(posedge clk);
    #1;
    reload = 0;
    chk("reload_loaded", 32'(loaded), 0);
    chk("reload_done", 32'(done), 0);
    chk("reload_cpu_rst", 32'(cpu_rst), 1);
    chk("reload_ready", 32'(in_ready), 1);
    chk("reload_err", 32'(err), 0);
    mdl_run = 0;
  endtask

  task automatic do_frame(input logic [7:0] len, input logic [127:0] data, input logic [7:0] ck,
                          input bit exp_run, input int maxgap);
    int         n, cnt;
    logic [7:0] b;
    if (mdl_run) do_reload();
    send(len, 0);
    if (len[7:4] != 4'd0) begin
      chk("badlen_err", 32'(err), 1);
      chk("badlen_ready", 32'(in_ready), 1);
      chk("badlen_cpu_rst", 32'(cpu_rst), 1);
      chk("badlen_loaded", 32'(loaded), 0);
      check_mem("badlen_mem");
      mdl_run = 0;
      return;
    end
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", 32'(cnt), 16);
    n = (len[3:0] == 4'd0) ? 16 : int'(len[3:0]);
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = data[8*i +: 8];
      send(b, $urandom_range(0, maxgap));
      mdl_mem[i] = b;
    end
    send(ck, 0);
    chk("frame_loaded", 32'(loaded), 32'(exp_run));
    chk("frame_err", 32'(err), 32'(!exp_run));
    chk("frame_cpu_rst", 32'(cpu_rst), 32'(!exp_run));
    chk("frame_ready", 32'(in_ready), 32'(!exp_run));
    chk("frame_done", 32'(done), 0);
    mdl_run = exp_run;
    check_mem("frame_mem");
  endtask

  initial begin
    logic [7:0]   len, sum, ck;
    logic [127:0] data;
    int           n;
    tbl[0] = '{8'h08, 128'hDFD12917B1A0908A, 8'h5B, 1'b1};
    tbl[1] = '{8'h08, 128'hDFD12917B1A0908A, 8'h5C, 1'b0};
    tbl[2] = '{8'h18, 128'h0, 8'h00, 1'b0};
    tbl[3] = '{8'h08, 128'hDFD12917B1A0908A, 8'h5B, 1'b1};
    tbl[4] = '{8'h00, 128'h100F0E0D0C0B0A090807060504030201, 8'h88, 1'b1};
    tbl[5] = '{8'h03, 128'h01AA55, 8'h00, 1'b1};
    #12;
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) begin
      do_frame(tbl[i].len, tbl[i].data, tbl[i].ck, tbl[i].exp_run, 2);
      if (tbl[i].exp_run) begin
        @(negedge clk);
        chk("done_before_ok", 32'(done), 0);
        cpu_ok = 1;
        @(posedge clk);
        #1;
        cpu_ok = 0;
        chk("done_after_ok", 32'(done), 1);
        @(negedge clk);
        chk("done_sticky", 32'(done), 1);
      end else begin
        @(negedge clk);
        reload = 1;
        @(posedge clk);
        #1;
        reload = 0;
        chk("reload_ignored_err", 32'(err), 1);
        chk("reload_ignored_ready", 32'(in_ready), 1);
        chk("reload_ignored_cpu_rst", 32'(cpu_rst), 1);
      end
      if (i == 4) begin
        fetch_addr = 4'd15;
        #1;
        chk("len0_addr15", 32'(fetch_inst), 32'h10);
      end
    end
    if (mdl_run) do_reload();
    send(8'h05, 0);
    send(8'hAA, 1);
    send(8'hBB, 1);
    send(8'hCC, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_load_cpu_rst", 32'(cpu_rst), 1);
    chk("arst_load_ready", 32'(in_ready), 1);
    chk("arst_load_loaded", 32'(loaded), 0);
    chk("arst_load_err", 32'(err), 0);
    #1 rst_n = 1;
    mdl_run = 0;
    do_frame(8'h04, 128'h44332211, 8'hAA, 1'b1, 2);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_run_cpu_rst", 32'(cpu_rst), 1);
    chk("arst_run_loaded", 32'(loaded), 0);
    chk("arst_run_ready", 32'(in_ready), 1);
    #1 rst_n = 1;
    mdl_run = 0;
    for (int r = 0; r < 10; r++) begin
      len  = ($urandom_range(0, 7) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)}
                                         : {4'h0, 4'($urandom)};
      data = {$urandom, $urandom, $urandom, $urandom};
      n    = (len[3:0] == 4'd0) ? 16 : int'(len[3:0]);
      sum  = 8'h00;
      for (int i = 0; i < n; i++) sum = sum + data[8*i +: 8];
      ck   = ($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum;
      do_frame(len, data, ck, ck == sum, 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
